// File: rtl/poly_nco_pkg.sv
// Shared types and constants for the polyphonic sine NCO.
// Holds the sweep FSM states, the gain-shift width and the sine table generator.
package poly_nco_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_OUT
   } nco_state_t;

   localparam int GAIN_W = 3;

   // round((2^(amp_w-1)-1) * sin(2*pi*k / 2^addr_w)), evaluated at elaboration
   function automatic int sine_entry(input int k, input int addr_w, input int amp_w);
      real pi, x, term, sum, scaled;
      pi = 3.14159265358979323846;
      x  = 2.0 * pi * real'(k) / real'(1 << addr_w);
      if (x > pi) x = x - 2.0 * pi;
      term = x;
      sum  = x;
      for (int n = 1; n <= 10; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      scaled = real'((1 << (amp_w - 1)) - 1) * sum;
      return (scaled >= 0.0) ? $rtoi(scaled + 0.5) : -$rtoi(0.5 - scaled);
   endfunction

endpackage

// File: rtl/sine_lut_q.sv
// Registered sine ROM: one full period, signed two's-complement samples,
// one cycle of read latency.
module sine_lut_q
   import poly_nco_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int AMP_W  = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic [ADDR_W-1:0]        addr_in,
   output logic signed [AMP_W-1:0]  data_out
);

   localparam int DEPTH = 1 << ADDR_W;

   logic signed [AMP_W-1:0] rom [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam int ENTRY = sine_entry(k, ADDR_W, AMP_W);
      assign rom[k] = ENTRY[AMP_W-1:0];
   end

   // NOTE: registered state is always written with <= so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) data_out <= '0;
      else        data_out <= rom[addr_in];
   end

endmodule

// File: rtl/poly_sine_nco.sv
// Multi-channel sine NCO: NUM_CH tuned tones summed per sample, sharing one
// registered sine LUT swept channel by channel after every accepted step.
module poly_sine_nco
   import poly_nco_pkg::*;
#(
   parameter  int NUM_CH     = 4,
   parameter  int PHASE_W    = 32,
   parameter  int LUT_ADDR_W = 6,
   parameter  int AMP_W      = 8,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int OUT_W      = AMP_W + $clog2(NUM_CH)
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     step_in,
   input  logic                     cfg_we_in,
   input  logic [CH_W-1:0]          cfg_ch_in,
   input  logic [PHASE_W-1:0]       cfg_incr_in,
   input  logic [GAIN_W-1:0]        cfg_gain_in,
   input  logic                     cfg_en_in,
   output logic signed [OUT_W-1:0]  sample_out,
   output logic                     sample_valid_out,
   output logic                     busy_out,
   output logic                     overrun_out
);

   logic [PHASE_W-1:0] phase_q      [NUM_CH];
   logic [PHASE_W-1:0] stage_incr_q [NUM_CH];
   logic [PHASE_W-1:0] act_incr_q   [NUM_CH];
   logic [GAIN_W-1:0]  stage_gain_q [NUM_CH];
   logic [GAIN_W-1:0]  act_gain_q   [NUM_CH];
   logic [NUM_CH-1:0]  stage_en_q, act_en_q, cfg_hit;

   nco_state_t              state_q, state_d;
   logic [CH_W-1:0]         ch_cnt_q;
   logic                    accept, issue, last_ch;
   logic [LUT_ADDR_W-1:0]   lut_addr;
   logic signed [AMP_W-1:0] lut_data, lut_shifted;
   logic                    lut_vld_q, lut_en_q;
   logic [GAIN_W-1:0]       lut_gain_q;
   logic signed [OUT_W-1:0] acc_q;

   // A step is taken only when idle and not inside the post-sample busy cycle.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      issue   = 1'b0;
      last_ch = (int'(ch_cnt_q) == NUM_CH - 1);
      unique case (state_q)
         ST_IDLE:  if (step_in && !busy_out) begin
                      accept  = 1'b1;
                      state_d = ST_ISSUE;
                   end
         ST_ISSUE: begin
                      issue = 1'b1;
                      if (last_ch) state_d = ST_DRAIN;
                   end
         ST_DRAIN: state_d = ST_OUT;
         ST_OUT:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) cfg_hit[i] = cfg_we_in && (int'(cfg_ch_in) == i);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= ST_IDLE;
         ch_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept)               ch_cnt_q <= '0;
         else if (issue && !last_ch) ch_cnt_q <= ch_cnt_q + CH_W'(1);
      end
   end

   // NOTE: these arrays sit on the reset because a reset must return every
   // tone to silence at phase 0; a plain RAM would not be cleared this way.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < NUM_CH; i++) begin
            phase_q[i]      <= '0;
            stage_incr_q[i] <= '0;
            act_incr_q[i]   <= '0;
            stage_gain_q[i] <= '0;
            act_gain_q[i]   <= '0;
         end
         stage_en_q <= '0;
         act_en_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_hit[i]) begin
               stage_incr_q[i] <= cfg_incr_in;
               stage_gain_q[i] <= cfg_gain_in;
               stage_en_q[i]   <= cfg_en_in;
            end
            // Same-cycle writes bypass staging so they join this sample.
            if (accept) begin
               act_incr_q[i] <= cfg_hit[i] ? cfg_incr_in : stage_incr_q[i];
               act_gain_q[i] <= cfg_hit[i] ? cfg_gain_in : stage_gain_q[i];
               act_en_q[i]   <= cfg_hit[i] ? cfg_en_in   : stage_en_q[i];
            end
            if (issue && int'(ch_cnt_q) == i)
               phase_q[i] <= act_en_q[i] ? phase_q[i] + act_incr_q[i] : '0;
         end
      end
   end

   assign lut_addr = phase_q[ch_cnt_q][PHASE_W-1 -: LUT_ADDR_W];

   sine_lut_q #(
      .ADDR_W (LUT_ADDR_W),
      .AMP_W  (AMP_W)
   ) u_lut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .addr_in  (lut_addr),
      .data_out (lut_data)
   );

   assign lut_shifted = lut_data >>> lut_gain_q;

   // Enable and gain ride one cycle behind the address to meet the LUT data.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         lut_vld_q  <= 1'b0;
         lut_en_q   <= 1'b0;
         lut_gain_q <= '0;
         acc_q      <= '0;
      end else begin
         lut_vld_q  <= issue;
         lut_en_q   <= act_en_q[ch_cnt_q];
         lut_gain_q <= act_gain_q[ch_cnt_q];
         if (accept)                     acc_q <= '0;
         else if (lut_vld_q && lut_en_q) acc_q <= acc_q + OUT_W'(lut_shifted);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sample_out       <= '0;
         sample_valid_out <= 1'b0;
         busy_out         <= 1'b0;
         overrun_out      <= 1'b0;
      end else begin
         sample_valid_out <= (state_q == ST_OUT);
         if (state_q == ST_OUT) sample_out <= acc_q;
         if (accept)                busy_out <= 1'b1;
         else if (sample_valid_out) busy_out <= 1'b0;
         if (step_in && busy_out) overrun_out <= 1'b1;
      end
   end

endmodule

// File: tb/tb_poly_sine_nco.sv
// Self-checking bench for poly_sine_nco: spec-derived vector table, hand-written
// corner sequences and a randomized run against a behavioural tone model.
module tb_poly_sine_nco;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;
   localparam int OUT_W  = 10;
   localparam int LAT    = NUM_CH + 2;

   logic                    clk_in = 1'b0;
   logic                    rst_in = 1'b1;
   logic                    step_in = 1'b0;
   logic                    cfg_we_in = 1'b0;
   logic [CH_W-1:0]         cfg_ch_in = '0;
   logic [31:0]             cfg_incr_in = '0;
   logic [2:0]              cfg_gain_in = '0;
   logic                    cfg_en_in = 1'b0;
   logic signed [OUT_W-1:0] sample_out;
   logic                    sample_valid_out;
   logic                    busy_out;
   logic                    overrun_out;

   poly_sine_nco dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .step_in          (step_in),
      .cfg_we_in        (cfg_we_in),
      .cfg_ch_in        (cfg_ch_in),
      .cfg_incr_in      (cfg_incr_in),
      .cfg_gain_in      (cfg_gain_in),
      .cfg_en_in        (cfg_en_in),
      .sample_out       (sample_out),
      .sample_valid_out (sample_valid_out),
      .busy_out         (busy_out),
      .overrun_out      (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic signed [63:0] actual,
                        input logic signed [63:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, actual, expected);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [31:0] m_phase [NUM_CH];
   logic [31:0] m_s_incr[NUM_CH], m_a_incr[NUM_CH];
   int          m_s_gain[NUM_CH], m_a_gain[NUM_CH];
   bit          m_s_en  [NUM_CH], m_a_en  [NUM_CH];

   function automatic int ref_sine(input int idx);
      real v;
      v = 127.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 64.0);
      return $rtoi($floor(v + 0.5));
   endfunction

   function automatic int shr_floor(input int v, input int g);
      int d, q;
      d = 1 << g;
      q = v / d;
      if (v < 0 && (v % d) != 0) q = q - 1;
      return q;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_phase[c] = '0; m_s_incr[c] = '0; m_a_incr[c] = '0;
         m_s_gain[c] = 0; m_a_gain[c] = 0; m_s_en[c] = 1'b0; m_a_en[c] = 1'b0;
      end
   endfunction

   function automatic void model_write(input int ch, input logic [31:0] incr,
                                       input int gain, input bit en);
      m_s_incr[ch] = incr; m_s_gain[ch] = gain; m_s_en[ch] = en;
   endfunction

   function automatic int model_step();
      int sum = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_a_incr[c] = m_s_incr[c]; m_a_gain[c] = m_s_gain[c]; m_a_en[c] = m_s_en[c];
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (m_a_en[c]) begin
            sum += shr_floor(ref_sine(int'(m_phase[c] >> 26)), m_a_gain[c]);
            m_phase[c] = m_phase[c] + m_a_incr[c];
         end else begin
            m_phase[c] = '0;
         end
      end
      return sum;
   endfunction

   // ---------------- drivers ----------------
   task automatic do_reset();
      @(negedge clk_in);
      rst_in = 1'b1;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      model_reset();
   endtask

   task automatic drive_cfg(input int ch, input logic [31:0] incr, input int gain, input bit en);
      cfg_we_in = 1'b1; cfg_ch_in = CH_W'(ch); cfg_incr_in = incr;
      cfg_gain_in = 3'(gain); cfg_en_in = en;
   endtask

   task automatic cfg_write(input int ch, input logic [31:0] incr, input int gain, input bit en);
      @(negedge clk_in);
      drive_cfg(ch, incr, gain, en);
      @(negedge clk_in);
      cfg_we_in = 1'b0;
   endtask

   // wr_when: 0 = no write, 1 = write in the step cycle, 2 = write mid-sweep
   task automatic run_step(input string name, input int wr_when, input int ch,
                           input logic [31:0] incr, input int gain, input bit en,
                           output logic signed [OUT_W-1:0] got, output int lat);
      got = 'x;
      lat = -1;
      @(negedge clk_in);
      step_in = 1'b1;
      if (wr_when == 1) drive_cfg(ch, incr, gain, en);
      @(negedge clk_in);
      step_in = 1'b0;
      cfg_we_in = 1'b0;
      if (wr_when == 2) begin
         check({name, " busy at mid write"}, busy_out, 1);
         drive_cfg(ch, incr, gain, en);
      end
      for (int c = 1; c <= LAT + 6; c++) begin
         @(negedge clk_in);
         cfg_we_in = 1'b0;
         if (sample_valid_out) begin
            lat = c;
            got = sample_out;
            break;
         end
      end
      check({name, " busy in valid cycle"}, busy_out, 1);
      @(negedge clk_in);
      check({name, " busy cleared"}, busy_out, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          rst;
      int          cfg_ch;
      logic [31:0] incr;
      int          gain;
      bit          en;
      bit          step;
      int          expect_sample;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit rst, input int cfg_ch, input logic [31:0] incr, input int gain,
                      input bit en, input bit step, input int exp_s, input string name);
      vec_t v;
      v.rst = rst; v.cfg_ch = cfg_ch; v.incr = incr; v.gain = gain; v.en = en;
      v.step = step; v.expect_sample = exp_s; v.name = name;
      vecs.push_back(v);
   endtask

   logic signed [OUT_W-1:0] got;
   int                      lat;
   int                      pulses;
   int                      seq_tone[8] = '{0, 90, 127, 90, 0, -90, -127, -90};
   int                      seq_duo[8]  = '{0, 180, 254, 180, 0, -180, -254, -180};
   int                      seq_gain[4] = '{0, 7, 0, -8};

   initial begin
      // single tone, ch0 at 1/8 cycle per sample
      add(1, 0, 32'h2000_0000, 0, 1, 1, seq_tone[0], "tone s0");
      for (int i = 1; i < 10; i++) add(0, -1, 0, 0, 0, 1, seq_tone[i % 8], $sformatf("tone s%0d", i));
      // two equal channels
      add(1, 0, 32'h2000_0000, 0, 1, 0, 0, "duo cfg");
      add(0, 1, 32'h2000_0000, 0, 1, 1, seq_duo[0], "duo s0");
      for (int i = 1; i < 8; i++) add(0, -1, 0, 0, 0, 1, seq_duo[i], $sformatf("duo s%0d", i));
      // quarter-cycle step with gain shift 4
      add(1, 0, 32'h4000_0000, 4, 1, 1, seq_gain[0], "gain s0");
      for (int i = 1; i < 6; i++) add(0, -1, 0, 0, 0, 1, seq_gain[i % 4], $sformatf("gain s%0d", i));

      // reset state
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      model_reset();
      @(negedge clk_in);
      check("reset sample_out", sample_out, 0);
      check("reset valid", sample_valid_out, 0);
      check("reset busy", busy_out, 0);
      check("reset overrun", overrun_out, 0);

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         if (vecs[i].cfg_ch >= 0) cfg_write(vecs[i].cfg_ch, vecs[i].incr, vecs[i].gain, vecs[i].en);
         if (vecs[i].step) begin
            run_step(vecs[i].name, 0, 0, 0, 0, 0, got, lat);
            check({vecs[i].name, " sample"}, got, vecs[i].expect_sample);
            check({vecs[i].name, " latency"}, lat, LAT);
         end
      end

      // deferred config: mid-sweep write only affects the following step
      do_reset();
      cfg_write(0, 32'h2000_0000, 0, 1);
      run_step("defer s0", 0, 0, 0, 0, 0, got, lat);
      check("defer s0 sample", got, 0);
      run_step("defer s1", 2, 0, 32'h4000_0000, 0, 1, got, lat);
      check("defer s1 sample", got, 90);
      run_step("defer s2", 0, 0, 0, 0, 0, got, lat);
      check("defer s2 sample", got, 127);
      run_step("defer s3", 0, 0, 0, 0, 0, got, lat);
      check("defer s3 sample", got, 0);
      run_step("defer s4", 0, 0, 0, 0, 0, got, lat);
      check("defer s4 sample", got, -127);

      // config write in the same cycle as the accepted step joins that sample
      do_reset();
      run_step("samecyc s0", 1, 0, 32'h2000_0000, 0, 1, got, lat);
      check("samecyc s0 sample", got, 0);
      run_step("samecyc s1", 0, 0, 0, 0, 0, got, lat);
      check("samecyc s1 sample", got, 90);

      // overrun: second step two cycles after the first is dropped
      do_reset();
      cfg_write(0, 32'h2000_0000, 0, 1);
      @(negedge clk_in); step_in = 1'b1;
      @(negedge clk_in); step_in = 1'b0;
      @(negedge clk_in); step_in = 1'b1;
      @(negedge clk_in); step_in = 1'b0;
      pulses = 0;
      for (int c = 0; c < LAT + 8; c++) begin
         @(negedge clk_in);
         if (sample_valid_out) begin
            pulses++;
            got = sample_out;
         end
      end
      check("overrun pulse count", pulses, 1);
      check("overrun sample", got, 0);
      check("overrun flag", overrun_out, 1);
      run_step("overrun next", 0, 0, 0, 0, 0, got, lat);
      check("overrun single advance", got, 90);
      check("overrun sticky", overrun_out, 1);

      // reset in the middle of a sweep
      do_reset();
      cfg_write(0, 32'h2000_0000, 0, 1);
      run_step("rstmid a", 0, 0, 0, 0, 0, got, lat);
      run_step("rstmid b", 0, 0, 0, 0, 0, got, lat);
      check("rstmid pre sample", got, 90);
      @(negedge clk_in); step_in = 1'b1;
      @(negedge clk_in); step_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      check("rstmid sample_out", sample_out, 0);
      check("rstmid busy", busy_out, 0);
      check("rstmid valid", sample_valid_out, 0);
      @(negedge clk_in);
      rst_in = 1'b0;
      model_reset();
      pulses = 0;
      for (int c = 0; c < LAT + 6; c++) begin
         @(negedge clk_in);
         if (sample_valid_out) pulses++;
      end
      check("rstmid no pulse", pulses, 0);
      cfg_write(0, 32'h2000_0000, 0, 1);
      run_step("rstmid c", 0, 0, 0, 0, 0, got, lat);
      check("rstmid first sample", got, 0);
      run_step("rstmid d", 0, 0, 0, 0, 0, got, lat);
      check("rstmid second sample", got, 90);

      // randomized tones against the behavioural model
      do_reset();
      for (int it = 0; it < 40; it++) begin
         int n_wr, mode, ch, gain, exp_s;
         logic [31:0] incr;
         bit en;
         n_wr = $urandom_range(0, 2);
         for (int w = 0; w < n_wr; w++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            incr = $urandom();
            gain = $urandom_range(0, 7);
            en = ($urandom_range(0, 3) != 0);
            cfg_write(ch, incr, gain, en);
            model_write(ch, incr, gain, en);
         end
         mode = $urandom_range(0, 2);
         ch = $urandom_range(0, NUM_CH - 1);
         incr = $urandom();
         gain = $urandom_range(0, 7);
         en = ($urandom_range(0, 3) != 0);
         if (mode == 1) model_write(ch, incr, gain, en);
         exp_s = model_step();
         if (mode == 2) model_write(ch, incr, gain, en);
         run_step($sformatf("rand %0d", it), mode, ch, incr, gain, en, got, lat);
         check($sformatf("rand %0d sample", it), got, exp_s);
         check($sformatf("rand %0d latency", it), lat, LAT);
      end
      check("rand no overrun", overrun_out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
